textmem_wb: RTL and testbench

Wishbone responder that holds the text-mode character memory and the cursor control registers for the VGA text path. It answers the text driver's read bursts, one word per transaction, and the CPU's read/write accesses. It drives the cursor position, mode and colour inputs of the text driver. It includes a hardware fill engine that clears the screen without CPU involvement.

---
 rtl/textmem_pkg.sv | 30 +++
 rtl/if_wb.sv | 16 +
 rtl/textmem_wb_textram_be.sv | 24 ++
 rtl/textmem_wb.sv | 169 ++++++++++++++++
 tb/tb_textmem_wb.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/textmem_pkg.sv
// Shared definitions for the text-mode memory responder: register offsets,
// controller states and the byte-lane merge helper.
package textmem_pkg;

    localparam logic [2:0] CURSORPOS   = 3'd0;
    localparam logic [2:0] CURSORMODE  = 3'd1;
    localparam logic [2:0] CURSORCOLOR = 3'd2;
    localparam logic [2:0] CTRL        = 3'd3;
    localparam logic [2:0] FILL        = 3'd4;

    localparam logic [23:0] CURSOR_COLOR_RST = 24'hffffff;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_ACK,
        S_CLEAR
    } tm_state_t;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? wr_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Wishbone bus bundle; the responder side uses the slave modport.
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic        ack;

    modport slave (
        input  adr, dat_i, cyc, stb, we, sel,
        output dat_o, ack
    );
endinterface

// File: rtl/textmem_wb_textram_be.sv
// Single-port text RAM, synchronous read-before-write, per-byte write enables.
module textram_be #(
    parameter int unsigned AWORDS = 1024,
    localparam int unsigned AW    = $clog2(AWORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [AWORDS];

    always_ff @(posedge clk_i) begin
        rdata <= mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/textmem_wb.sv
// Wishbone responder for the text character RAM, cursor registers and a
// hardware fill engine that clears the whole RAM.
module textmem_wb
    import textmem_pkg::*;
#(
    parameter int unsigned AWORDS   = 1024,
    parameter logic [31:0] FILL_RST = 32'h0f200f20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_wb.slave         bus,
    output logic [31:0] cursorpos,
    output logic [3:0]  cursormode,
    output logic [23:0] cursorcolor
);

    localparam int unsigned    AW   = $clog2(AWORDS);
    localparam logic [AW-1:0] LAST = AW'(AWORDS - 1);

    tm_state_t     state;
    logic          pend;
    logic [10:0]   req_adr;
    logic [31:0]   req_dat;
    logic          req_we;
    logic [3:0]    req_sel;
    logic [AW-1:0] cnt;
    logic [31:0]   fill;
    logic          clear_go;
    logic          ack_q;
    logic [31:0]   dat_q;

    logic          req_ram;
    logic [2:0]    req_off;
    logic [31:0]   reg_rd;
    logic [31:0]   reg_wr;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          unused_adr;

    assign unused_adr = ^{bus.adr[31:13], bus.adr[1:0]};

    assign req_ram  = !req_adr[10];
    assign req_off  = req_adr[2:0];
    assign bus.ack  = ack_q;
    assign bus.dat_o = dat_q;

    always_comb begin
        reg_rd = '0;
        unique case (req_off)
            CURSORPOS:   reg_rd = cursorpos;
            CURSORMODE:  reg_rd = {28'd0, cursormode};
            CURSORCOLOR: reg_rd = {8'd0, cursorcolor};
            CTRL:        reg_rd = {31'd0, state == S_CLEAR};
            FILL:        reg_rd = fill;
            default:     reg_rd = '0;
        endcase
        reg_wr = merge_be(reg_rd, req_dat, req_sel);
    end

    // Fill engine owns the RAM port for the whole clear; otherwise the bus request does.
    always_comb begin
        ram_addr  = req_adr[AW-1:0];
        ram_wdata = req_dat;
        ram_we    = '0;
        if (state == S_CLEAR) begin
            ram_addr  = cnt;
            ram_wdata = fill;
            ram_we    = 4'hf;
        end else if (state == S_IDLE && pend && bus.cyc && req_we && req_ram) begin
            ram_we = req_sel;
        end
    end

    textram_be #(
        .AWORDS (AWORDS)
    ) u_ram (
        .clk_i (clk_i),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            pend        <= 1'b0;
            req_adr     <= '0;
            req_dat     <= '0;
            req_we      <= 1'b0;
            req_sel     <= '0;
            cnt         <= '0;
            fill        <= FILL_RST;
            clear_go    <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            cursorpos   <= '0;
            cursormode  <= '0;
            cursorcolor <= CURSOR_COLOR_RST;
        end else begin
            if (bus.cyc && bus.stb && !pend) begin
                pend    <= 1'b1;
                req_adr <= bus.adr[12:2];
                req_dat <= bus.dat_i;
                req_we  <= bus.we;
                req_sel <= bus.sel;
            end

            unique case (state)
                S_IDLE: begin
                    if (pend) begin
                        if (!bus.cyc) begin
                            pend <= 1'b0;
                        end else if (req_ram && !req_we) begin
                            state <= S_READ;
                        end else begin
                            if (!req_we) begin
                                dat_q <= reg_rd;
                            end else if (!req_ram) begin
                                unique case (req_off)
                                    CURSORPOS:   cursorpos   <= reg_wr;
                                    CURSORMODE:  cursormode  <= reg_wr[3:0];
                                    CURSORCOLOR: cursorcolor <= reg_wr[23:0];
                                    CTRL:        clear_go    <= req_sel[0] && req_dat[0];
                                    FILL:        fill        <= reg_wr;
                                    default:     ;
                                endcase
                            end
                            ack_q <= 1'b1;
                            state <= S_ACK;
                        end
                    end
                end
                S_READ: begin
                    if (!bus.cyc) begin
                        pend  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        dat_q <= ram_rdata;
                        ack_q <= 1'b1;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q    <= 1'b0;
                    pend     <= 1'b0;
                    clear_go <= 1'b0;
                    state    <= clear_go ? S_CLEAR : S_IDLE;
                end
                S_CLEAR: begin
                    // Requests that arrive now wait in pend until the clear is done.
                    if (pend && !bus.cyc) begin
                        pend <= 1'b0;
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_textmem_wb.sv
// Directed self-checking bench for textmem_wb.
module tb_textmem_wb;

    logic        clk;
    logic        rst;
    logic [31:0] cursorpos;
    logic [3:0]  cursormode;
    logic [23:0] cursorcolor;

    if_wb wb ();

    textmem_wb #(
        .AWORDS   (1024),
        .FILL_RST (32'h0f200f20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (wb),
        .cursorpos   (cursorpos),
        .cursormode  (cursormode),
        .cursorcolor (cursorcolor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd;
    int          lat;
    logic        ack_after;
    logic [31:0] pos_ack;
    logic [3:0]  mode_ack;
    int          acks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: single-cycle stb, cyc held; lat counts cycles from capture to ack.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] s);
        @(posedge clk); #1;
        wb.adr = a; wb.dat_i = d; wb.we = w; wb.sel = s; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk); #1;
        wb.stb = 1'b0;
        lat = -1;
        rd  = 'x;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (wb.ack === 1'b1) begin
                lat      = k;
                rd       = wb.dat_o;
                pos_ack  = cursorpos;
                mode_ack = cursormode;
                break;
            end
        end
        @(negedge clk);
        ack_after = wb.ack;
    endtask

    function automatic logic [31:0] burst_word(input int i);
        return {8'hc0, 8'(i), 8'h3c, 8'(i) ^ 8'hff};
    endfunction

    initial begin
        rst = 1'b1;
        wb.adr = '0; wb.dat_i = '0; wb.we = 1'b0; wb.sel = '0; wb.cyc = 1'b0; wb.stb = 1'b0;
        #12;
        check("rst_ack", {31'd0, wb.ack}, 32'd0);
        check("rst_dat_o", wb.dat_o, 32'd0);
        check("rst_cursorcolor", {8'd0, cursorcolor}, 32'h00ffffff);
        check("rst_cursorpos", cursorpos, 32'd0);
        check("rst_cursormode", {28'd0, cursormode}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        xfer(32'h1010, 32'd0, 1'b0, 4'hf);
        check("fill_rst_read", rd, 32'h0f200f20);
        check("reg_read_lat", lat, 2);
        check("ack_width", {31'd0, ack_after}, 32'd0);

        xfer(32'h0008, 32'hdeadbeef, 1'b1, 4'hf);
        check("ram_write_lat", lat, 2);
        xfer(32'h0008, 32'h12345678, 1'b1, 4'b0011);
        xfer(32'h0008, 32'd0, 1'b0, 4'hf);
        check("ram_byte_write", rd, 32'hdead5678);
        check("ram_read_lat", lat, 3);
        check("ram_ack_width", {31'd0, ack_after}, 32'd0);

        for (int i = 0; i < 40; i++) xfer(32'(4 * i), burst_word(i), 1'b1, 4'hf);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            xfer(32'(4 * i), 32'd0, 1'b0, 4'hf);
            if (lat == 3) acks++;
            check($sformatf("burst_%0d", i), rd, burst_word(i));
        end
        check("burst_acks", acks, 40);

        // Abandoned read: cyc drops one cycle after capture.
        @(posedge clk); #1;
        wb.adr = 32'h0004; wb.we = 1'b0; wb.sel = 4'hf; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk); #1;
        wb.stb = 1'b0;
        @(posedge clk); #1;
        wb.cyc = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb.ack === 1'b1) acks++;
        end
        check("abort_no_ack", acks, 0);
        xfer(32'h0004, 32'd0, 1'b0, 4'hf);
        check("after_abort_data", rd, burst_word(1));
        check("after_abort_lat", lat, 3);

        xfer(32'h1000, 32'h00030010, 1'b1, 4'hf);
        check("cursorpos_at_ack", pos_ack, 32'h00030010);
        xfer(32'h1004, 32'h00000002, 1'b1, 4'hf);
        check("cursormode_at_ack", {28'd0, mode_ack}, 32'd2);
        xfer(32'h1008, 32'h00123456, 1'b1, 4'b0100);
        check("cursorcolor_bytelane", {8'd0, cursorcolor}, 32'h0012ffff);
        xfer(32'h1000, 32'd0, 1'b0, 4'hf);
        check("cursorpos_readback", rd, 32'h00030010);

        xfer(32'h101c, 32'd0, 1'b0, 4'hf);
        check("unmapped_read", rd, 32'd0);
        check("unmapped_lat", lat, 2);

        xfer(32'h1010, 32'h07410741, 1'b1, 4'hf);
        xfer(32'h1014, 32'hffffffff, 1'b1, 4'hf);
        check("unmapped_write_lat", lat, 2);
        xfer(32'h1010, 32'd0, 1'b0, 4'hf);
        check("fill_readback", rd, 32'h07410741);

        xfer(32'h100c, 32'h00000001, 1'b1, 4'hf);
        check("ctrl_write_lat", lat, 2);
        xfer(32'h100c, 32'd0, 1'b0, 4'hf);
        check("poll_busy_done", rd, 32'd0);
        checks++;
        assert (lat >= 1000 && lat <= 1040) else begin
            failures++;
            $error("FAIL poll_delay observed=%0d expected=1000..1040", lat);
        end
        xfer(32'h0000, 32'd0, 1'b0, 4'hf);
        check("clear_word0", rd, 32'h07410741);
        xfer(32'h0ffc, 32'd0, 1'b0, 4'hf);
        check("clear_word1023", rd, 32'h07410741);
        xfer(32'h0008, 32'd0, 1'b0, 4'hf);
        check("clear_word2", rd, 32'h07410741);

        xfer(32'h100c, 32'h00000000, 1'b1, 4'hf);
        xfer(32'h100c, 32'd0, 1'b0, 4'hf);
        check("ctrl0_no_clear", rd, 32'd0);
        check("ctrl0_poll_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
